// File: rtl/lfsr_seq.sv
// lfsr_seq - sequential front end for the 411-bit, 12-bit-per-step scrambler.
//
// Loads a seed, consumes a counted stream of 12-bit chunks over a valid/ready
// handshake (one scrambler step per accepted chunk), and holds the final
// state as a result until the next job is started.
//
// Optional build macro:
//   LFSR_SEQ_BITREV_EN - when defined, each chunk is bit-reversed before the
//                        step so bit CHUNK_W-1 is applied first (MSB-first).
//                        When undefined, bit 0 is applied first.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   start        in   one-cycle job request, honoured only in IDLE or DONE
//   seed         in   initial state, sampled when start is honoured
//   num_chunks   in   chunk count of the job, sampled with start
//   in_valid     in   in_data carries a chunk
//   in_data      in   12-bit chunk
//   in_ready     out  a chunk is accepted this cycle if in_valid is high
//   busy         out  job in progress
//   done         out  one-cycle pulse on entry to DONE
//   result       out  final state, valid while result_valid is high
//   result_valid out  high while in DONE

// lfsr_7 - combinational scrambler stage: applies CHUNK_W single-bit steps.
// Each bit step shifts the state up by one; the bit falling out of the top
// feeds back into bit 0 (mixed with the data bit) and into the tap positions.
module lfsr_7 #(
  parameter int STATE_W = 411,
  parameter int CHUNK_W = 12
) (
  input  logic [STATE_W-1:0] state_in,
  input  logic [CHUNK_W-1:0] chunk_in,
  output logic [STATE_W-1:0] state_out
);

  logic [STATE_W-1:0] s;
  logic               msb;

  // Bits are consumed from chunk_in[0] upward; callers reorder the chunk
  // beforehand if another serial order is wanted.
  always_comb begin
    s   = state_in;
    msb = 1'b0;
    for (int i = 0; i < CHUNK_W; i++) begin
      msb = s[STATE_W-1];
      s   = {s[STATE_W-2:0], msb ^ chunk_in[i]};
      s[31]  = s[31]  ^ msb;
      s[60]  = s[60]  ^ msb;
      s[190] = s[190] ^ msb;
      s[195] = s[195] ^ msb;
      s[245] = s[245] ^ msb;
    end
  end

  assign state_out = s;

endmodule

module lfsr_seq #(
  parameter int STATE_W = 411,
  parameter int CHUNK_W = 12,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] seed,
  input  logic [LEN_W-1:0]   num_chunks,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_data,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] result,
  output logic               result_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         fsm;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] result_q;
  logic [LEN_W-1:0]   cnt;
  logic               done_q;
  logic [CHUNK_W-1:0] step_data;
  logic [STATE_W-1:0] next_state;
  logic               transfer;

  // Optional MSB-first ordering is just a wire swap ahead of the step.
`ifdef LFSR_SEQ_BITREV_EN
  always_comb begin
    step_data = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      step_data[i] = in_data[CHUNK_W-1-i];
    end
  end
`else
  assign step_data = in_data;
`endif

  lfsr_7 #(
    .STATE_W (STATE_W),
    .CHUNK_W (CHUNK_W)
  ) u_step (
    .state_in  (state_q),
    .chunk_in  (step_data),
    .state_out (next_state)
  );

  assign transfer = (fsm == RUN) && in_valid;

  // Job control. IDLE and DONE share the start path; a zero-length job goes
  // straight to DONE with the seed as its result. In RUN the last transfer
  // (cnt==1) captures the post-step state into the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= IDLE;
      state_q  <= '0;
      result_q <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE, DONE: begin
          if (start) begin
            state_q <= seed;
            cnt     <= num_chunks;
            if (num_chunks == '0) begin
              fsm      <= DONE;
              result_q <= seed;
              done_q   <= 1'b1;
            end else begin
              fsm <= RUN;
            end
          end
        end
        RUN: begin
          if (transfer) begin
            state_q <= next_state;
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end
            if (cnt == LEN_W'(1)) begin
              fsm      <= DONE;
              result_q <= next_state;
              done_q   <= 1'b1;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign in_ready     = (fsm == RUN);
  assign busy         = (fsm == RUN);
  assign result_valid = (fsm == DONE);
  assign done         = done_q;
  assign result       = result_q;

endmodule

// File: tb/tb_lfsr_seq.sv
// tb_lfsr_seq - self-checking bench for lfsr_seq.
// Expected results come from a bench-side model of the scrambler, pushed to a
// scoreboard queue when a job is started and popped when the DUT signals done.
module tb_lfsr_seq;

  localparam int STATE_W = 411;
  localparam int CHUNK_W = 12;
  localparam int LEN_W   = 16;

  logic               clk;
  logic               rst;
  logic               start;
  logic [STATE_W-1:0] seed;
  logic [LEN_W-1:0]   num_chunks;
  logic               in_valid;
  logic [CHUNK_W-1:0] in_data;
  logic               in_ready;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] result;
  logic               result_valid;

  int checks = 0;
  int errors = 0;

  logic [STATE_W-1:0] exp_q[$];
  logic [CHUNK_W-1:0] chunk_q[$];

  lfsr_seq #(
    .STATE_W (STATE_W),
    .CHUNK_W (CHUNK_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .num_chunks   (num_chunks),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference scrambler: shift-and-xor-mask form of the bit step.
  function automatic logic [STATE_W-1:0] model_chunk(input logic [STATE_W-1:0] s_in,
                                                     input logic [CHUNK_W-1:0] d);
    logic [STATE_W-1:0] s;
    logic [STATE_W-1:0] mask;
    logic               fb;
    int                 idx;
    s    = s_in;
    mask = '0;
    mask[0] = 1'b1; mask[31] = 1'b1; mask[60] = 1'b1;
    mask[190] = 1'b1; mask[195] = 1'b1; mask[245] = 1'b1;
    for (int i = 0; i < CHUNK_W; i++) begin
`ifdef LFSR_SEQ_BITREV_EN
      idx = CHUNK_W - 1 - i;
`else
      idx = i;
`endif
      fb = s[STATE_W-1];
      s  = s << 1;
      if (fb) s = s ^ mask;
      s[0] = s[0] ^ d[idx];
    end
    return s;
  endfunction

  function automatic logic [STATE_W-1:0] model_job(input logic [STATE_W-1:0] s_in);
    logic [STATE_W-1:0] s;
    s = s_in;
    foreach (chunk_q[i]) s = model_chunk(s, chunk_q[i]);
    return s;
  endfunction

  task automatic start_job(input logic [STATE_W-1:0] s, input logic [LEN_W-1:0] n);
    @(negedge clk);
    start      = 1'b1;
    seed       = s;
    num_chunks = n;
    exp_q.push_back(model_job(s));
    @(negedge clk);
    start      = 1'b0;
    seed       = '0;
    num_chunks = '0;
  endtask

  // Streams the first n entries of chunk_q; returns at the negedge after the
  // last transfer. done must stay low while streaming.
  task automatic stream_chunks(input int n, input bit gapped, output int cycles);
    int  sent;
    bit  phase;
    sent   = 0;
    phase  = 1'b1;
    cycles = 0;
    while (sent < n && cycles < 4 * n + 10) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL early_done: got %b expected 0 (cycle %0d)", done, cycles);
      end
      in_valid = gapped ? phase : 1'b1;
      in_data  = in_valid ? chunk_q[sent] : CHUNK_W'($urandom);
      if (in_valid && in_ready) sent++;
      phase = ~phase;
      @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("[TB] FAIL transfer_timeout: got %0d transfers expected %0d", sent, n);
    end
  endtask

  task automatic expect_result(input string name);
    logic [STATE_W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected an entry", name);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_done: got %b expected 1", name, done);
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_result_valid: got %b expected 1", name, result_valid);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("[TB] FAIL %s_result: got %h expected %h", name, result, exp);
    end
    // done is a single pulse; result is held afterwards.
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result_valid !== 1'b1 || result !== exp) begin
      errors++;
      $display("[TB] FAIL %s_hold: got done=%b rv=%b expected done=0 rv=1 held result",
               name, done, result_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, busy, done, result_valid} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b busy=%b done=%b rv=%b res=%h expected all 0",
               in_ready, busy, done, result_valid, result);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = CHUNK_W'($urandom);
      @(negedge clk);
      checks++;
      if ({in_ready, busy, done, result_valid} !== 4'b0000 || result !== '0) begin
        errors++;
        $display("[TB] FAIL idle_no_change: got rdy=%b busy=%b done=%b rv=%b expected all 0",
                 in_ready, busy, done, result_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_single_bit();
    logic [STATE_W-1:0] want;
    int cyc;
    want = '0;
`ifdef LFSR_SEQ_BITREV_EN
    want[0] = 1'b1;
`else
    want[11] = 1'b1;
`endif
    chunk_q = '{12'h001};
    start_job('0, 16'd1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_flags: got rdy=%b busy=%b expected 1 1", in_ready, busy);
    end
    stream_chunks(1, 1'b0, cyc);
    checks++;
    if (result !== want) begin
      errors++;
      $display("[TB] FAIL single_bit_const: got %h expected %h", result, want);
    end
    expect_result("single_bit");
  endtask

  task automatic test_tap_spread();
    logic [STATE_W-1:0] s;
    logic [STATE_W-1:0] want;
    int cyc;
    s = '0;
    s[410] = 1'b1;
    want = '0;
    want[11] = 1'b1; want[42] = 1'b1; want[71] = 1'b1;
    want[201] = 1'b1; want[206] = 1'b1; want[256] = 1'b1;
    chunk_q = '{12'h000};
    start_job(s, 16'd1);
    stream_chunks(1, 1'b0, cyc);
    checks++;
    if (result !== want) begin
      errors++;
      $display("[TB] FAIL tap_spread_const: got %h expected %h", result, want);
    end
    expect_result("tap_spread");
  endtask

  task automatic test_gapped_valid();
    int cyc;
    int pulses;
    chunk_q = '{12'h000, 12'h000, 12'h000};
    start_job('0, 16'd3);
    stream_chunks(3, 1'b1, cyc);
    checks++;
    if (cyc != 5) begin
      errors++;
      $display("[TB] FAIL gapped_cycles: got %0d expected 5", cyc);
    end
    expect_result("gapped");
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== '0) begin
      errors++;
      $display("[TB] FAIL gapped_extra_done: got %0d extra pulses expected 0", pulses);
    end
  endtask

  task automatic test_zero_len();
    logic [STATE_W-1:0] s;
    s = STATE_W'(12'h5A5);
    chunk_q = {};
    start_job(s, 16'd0);
    checks++;
    if (in_ready !== 1'b0 || result !== s) begin
      errors++;
      $display("[TB] FAIL zero_len: got rdy=%b res=%h expected 0 %h", in_ready, result, s);
    end
    expect_result("zero_len");
  endtask

  task automatic test_back_to_back();
    logic [STATE_W-1:0] s;
    int cyc;
    for (int i = 0; i < STATE_W; i++) s[i] = 1'($urandom_range(0, 1));
    chunk_q = {};
    for (int i = 0; i < 6; i++) chunk_q.push_back(CHUNK_W'($urandom));
    // DUT is in DONE here; a new start must drop result_valid next cycle.
    start_job(s, 16'd6);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_from_done: got rv=%b busy=%b expected 0 1", result_valid, busy);
    end
    stream_chunks(6, 1'b0, cyc);
    checks++;
    if (cyc != 6) begin
      errors++;
      $display("[TB] FAIL b2b_cycles: got %0d expected 6", cyc);
    end
    expect_result("back_to_back");
  endtask

  task automatic test_reset_mid_run();
    logic [STATE_W-1:0] want;
    int cyc;
    chunk_q = {};
    for (int i = 0; i < 4; i++) chunk_q.push_back(CHUNK_W'($urandom));
    start_job('1, 16'd4);
    stream_chunks(2, 1'b0, cyc);
    void'(exp_q.pop_back());
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, busy, done, result_valid} !== 4'b0000 || result !== '0) begin
      errors++;
      $display("[TB] FAIL mid_run_reset: got rdy=%b busy=%b done=%b rv=%b res=%h expected all 0",
               in_ready, busy, done, result_valid, result);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got rdy=%b expected 0", in_ready);
    end
    want = '0;
`ifdef LFSR_SEQ_BITREV_EN
    want[11] = 1'b1;
`else
    want[0] = 1'b1;
`endif
    chunk_q = '{12'h800};
    start_job('0, 16'd1);
    stream_chunks(1, 1'b0, cyc);
    checks++;
    if (result !== want) begin
      errors++;
      $display("[TB] FAIL after_reset_const: got %h expected %h", result, want);
    end
    expect_result("after_reset");
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    num_chunks = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    test_reset();
    test_single_bit();
    test_tap_spread();
    test_gapped_valid();
    test_zero_len();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_seq.md
Name: lfsr_seq

Overview:
Sequential front end for the combinational 411-bit, 12-bit-per-step scrambler stage (lfsr_7), which it instantiates.
- Loads a seed.
- Accepts a stream of 12-bit chunks over a valid/ready handshake and applies one scrambler step per accepted chunk.
- Registers the 411-bit state between steps.
- Presents the final state as a held result.
Sits between the message source and the downstream consumer of the scrambled/CRC state.

Parameters:
STATE_W, 411, state width; must match the scrambler step.
CHUNK_W, 12, bits consumed per step; must match the scrambler step.
LEN_W, 16, width of the chunk-count input.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a job; honoured only in IDLE or DONE.
seed  in  STATE_W  initial state, sampled when start is honoured.
num_chunks  in  LEN_W  chunks in the job, sampled when start is honoured.
in_valid  in  1  in_data is valid.
in_data  in  CHUNK_W  chunk; bit 0 is applied first unless LFSR_SEQ_BITREV_EN is defined.
in_ready  out  1  block accepts a chunk this cycle.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse on entry to DONE.
result  out  STATE_W  final state; valid while result_valid is high.
result_valid  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state FSM goes to IDLE.
  - State register, remaining counter and result are all zero.
  - in_ready, busy, done and result_valid are all 0.
- FSM IDLE:
  - in_ready=0.
  - On start: state <= seed and cnt <= num_chunks.
  - If num_chunks==0, go to DONE (result=seed); otherwise go to RUN.
- FSM RUN:
  - in_ready=1 and busy=1.
  - Transfer occurs when in_valid&&in_ready.
  - On transfer: state <= step(state, in_data) and cnt <= cnt-1.
  - If cnt==1 at transfer, go to DONE next cycle with result = the post-step state.
  - No transfer: state and cnt hold.
  - start is ignored in RUN; no restart and no abort.
- FSM DONE:
  - result_valid=1 and result is held.
  - done pulses high for the first DONE cycle only.
  - On start: behaves as in IDLE, and result_valid drops the cycle after start.
  - With no start, DONE is held indefinitely.
- Latency and throughput:
  - One chunk per cycle, back-to-back.
  - result_valid is asserted the cycle after the last transfer.
  - A job of N chunks with in_valid continuously high takes N+1 cycles from start to result_valid.
- Step function, applied per bit b in application order, with msb = state[410]:
  - new[0] = msb^b.
  - new[k] = state[k-1]^msb for k in {31,60,190,195,245}.
  - new[k] = state[k-1] for all other k.
  - A chunk applies 12 such bit steps.
- Width: cnt is LEN_W bits and never decrements below zero.
- in_data is ignored when no transfer occurs.
- Reset mid-RUN: the job is discarded immediately; the next job needs a new start.

Optional Feature:
LFSR_SEQ_BITREV_EN.
- Defined: in_data is bit-reversed before the step, so bit CHUNK_W-1 is applied first (MSB-first serial order).
- Undefined: bit 0 is applied first.
- No other behaviour changes.

Test Plan:
- Reset then idle: result=0, result_valid=0, in_ready=0, done=0; in_valid pulses produce no state change.
- seed=0, num_chunks=1, in_data=12'h001 -> after 1 transfer, result has only bit 11 set. With BITREV_EN, result has only bit 0 set.
- seed = only bit 410 set, num_chunks=1, in_data=0 -> result has bits {11,42,71,201,206,256} set, all others 0.
- seed=0, num_chunks=3, in_data=0 with in_valid toggling 1,0,1,0,1 -> exactly 3 transfers; result=0; done pulses once, the cycle after the 3rd transfer.
- num_chunks=0, seed=411'h5A5 -> DONE on the next cycle with result=411'h5A5; in_ready stays 0.
- Assert rst mid-RUN after 2 of 4 chunks -> all outputs 0 immediately. A new start with seed=0, num_chunks=1, in_data=12'h800 -> result has only bit 0 set.
